uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Buffered byte source sitting directly upstream of the UART top-level transmitter.
- Accepts bytes from a host-side write port into a synchronous FIFO.
- Presents each byte on tx_data and pulses the start/busy handshake so that the transmitter sends bytes back-to-back without host pacing.
- Reports per-byte completion, overflow, and a handshake timeout.

Parameters:
WIDTH, 8, data byte width; matches the UART top-level WIDTH
DEPTH, 16, FIFO entries; power of 2, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
ACK_TIMEOUT, 1024, cycles start may stay high without busy rising before the byte is abandoned

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
wr_en  in  1  host write strobe
wr_data  in  WIDTH  host byte
full  out  1  FIFO holds DEPTH entries
level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
start  out  1  to the UART start input; request to transmit tx_data
tx_data  out  WIDTH  to the UART TX_data_in
busy  in  1  from the UART; high while a frame is in flight
tx_done  out  1  one-cycle pulse when busy falls after a byte is sent
overflow  out  1  sticky; set by a write rejected while full
ack_err  out  1  sticky; set on handshake timeout
clr_err  in  1  clears overflow and ack_err

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge clears everything. Reset applies mid-frame too; the UART is not aborted, the FIFO contents are lost, and start is low after that edge.
  - FIFO pointers and level: 0
  - full, start, tx_done, overflow, ack_err: 0
  - tx_data: 0
  - FSM: IDLE
  - timeout counter: 0
- Write rules:
  - wr_en && !full stores wr_data at the tail, and level increments at the next edge.
  - wr_en while full, with no pop in that cycle: data is dropped, overflow is set, level is unchanged.
  - Write and pop in the same cycle while full: the write is accepted and level is unchanged.
  - Write and pop in the same cycle while level==1: both happen, and level stays 1.
- full = (level==DEPTH), registered with level.
- FSM states:
  - IDLE: if level!=0 && !busy, pop the head into the tx_data register, clear the timeout counter, and go to ARM. start is 1 from the next edge.
    - If busy is high in IDLE (foreign frame), do not pop.
  - ARM: start=1, and the timeout counter increments every cycle.
    - busy==1: go to SEND and drop start at that edge.
    - Otherwise, when the counter reaches ACK_TIMEOUT-1: set ack_err, drop start, go to IDLE. The byte is discarded and is not retried.
  - SEND: start=0. When busy==0, pulse tx_done for exactly one cycle and go to IDLE.
- Latency: a write at edge N into an empty FIFO while the FSM is in IDLE and busy is low gives level=1 after N, pop at N+1, and start=1 after N+1 (2 cycles).
- Back-to-back: after tx_done, the next pop occurs on the following cycle if level!=0. There is no minimum gap.
- tx_data is held constant from the pop until the FSM returns to IDLE. It changes only on a pop.
- clr_err clears both sticky flags at the edge. If a set event occurs in the same cycle, set wins.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH and never underflows.

Decomposition:
- Shared package uart_pkg holds:
  - the default WIDTH
  - FSM state encoding localparams (ST_IDLE, ST_ARM, ST_SEND; 2-bit)
  - the default ACK_TIMEOUT
- One sub-module, uart_sync_fifo (WIDTH, DEPTH):
  - push/pop/full/level
  - simultaneous push-on-full-with-pop handled inside the sub-module
- The feeder adds the FSM, timeout counter, sticky flags and tx_data register.
- Total about 200–300 RTL lines.

Test Plan:
- Single byte: reset, write 8'hD3 with busy model rising 2 cycles after start and lasting 50 cycles.
  - start high 2 cycles after the write; tx_data=8'hD3; start low the cycle busy rises; tx_done one pulse after busy falls; level returns to 0.
- Burst of 4 bytes 8'h01..8'h04 in consecutive cycles.
  - level peaks at 3 or 4; bytes leave in order 01,02,03,04; four tx_done pulses; start never high while busy is high after ARM exits.
- Fill to DEPTH=16 with busy held high, then write 8'hAA.
  - full=1, overflow=1, level=16; write and pop in the same cycle after busy releases is accepted, with level staying 16.
- Timeout with ACK_TIMEOUT=8 and busy tied low.
  - start high exactly 8 cycles then drops; ack_err=1; next queued byte armed; clr_err clears ack_err the next cycle.
- Reset mid-SEND with 3 bytes queued.
  - After the reset edge: level=0, start=0, tx_data=0, flags 0; no tx_done when busy later falls.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: default widths, timeout and FSM encoding.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

  localparam int UART_WIDTH       = 8;
  localparam int UART_ACK_TIMEOUT = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int ack_cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level/full; head_data is the entry at the read pointer.
// Push and pop take effect at the edge; a push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head_data,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              drop
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W:0]   level_nxt;

  assign do_pop  = pop && (level != '0);
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + (ADDR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      level_nxt = level - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == (ADDR_W+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and drives the UART start/busy handshake so frames go out back-to-back.
// Write-to-start latency 2 cycles; writes while full are dropped and flagged, a missing busy is abandoned after ACK_TIMEOUT.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int WIDTH       = UART_WIDTH,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              start,
  output logic [WIDTH-1:0]  tx_data,
  input  logic              busy,
  output logic              tx_done,
  output logic              overflow,
  output logic              ack_err,
  input  logic              clr_err
);

  localparam int CNT_W = ack_cnt_width(ACK_TIMEOUT);

  logic [1:0]       state;
  logic [CNT_W-1:0] ack_cnt;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             drop;
  logic             timeout;

  // A busy line while idle belongs to someone else's frame, so hold off.
  assign pop     = (state == ST_IDLE) && (level != '0) && !busy;
  assign timeout = (state == ST_ARM) && !busy && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

  uart_sync_fifo #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .level     (level),
    .drop      (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      start   <= 1'b0;
      tx_data <= '0;
      tx_done <= 1'b0;
      ack_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data <= head_data;
            ack_cnt <= '0;
            start   <= 1'b1;
            state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (busy) begin
            start <= 1'b0;
            state <= ST_SEND;
          end else if (timeout) begin
            // The byte is abandoned rather than retried.
            start <= 1'b0;
            state <= ST_IDLE;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (!busy) begin
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          start <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      overflow <= drop || (overflow && !clr_err);
      ack_err  <= timeout || (ack_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus random traffic against a queue-based byte model.
module tb_uart_tx_feeder;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              start;
  logic [WIDTH-1:0]  tx_data;
  logic              busy;
  logic              tx_done;
  logic              overflow;
  logic              ack_err;
  logic              clr_err;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .tx_done  (tx_done),
    .overflow (overflow),
    .ack_err  (ack_err),
    .clr_err  (clr_err)
  );

  int vecs = 0;
  int errs = 0;

  // Model: bytes held in the FIFO, bytes expected on the wire, bytes actually presented.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       model_ovf;
  int         lvl_mis, spur, done_cnt, max_lvl, sb_viol;
  logic       prev_start, prev_sb;

  // UART stand-in: mode 0 answers start after rsp_dly cycles for rsp_len cycles, 1 forces busy high, 2 forces low.
  int busy_mode, rsp_dly, rsp_len, rsp_wait, rsp_left;

  // One clock: called at a negedge, drives inputs for the coming posedge, returns at the next negedge.
  task automatic cyc(input logic r, input logic we, input logic [7:0] wd, input logic ce);
    int   pre;
    logic popped;
    if (busy_mode == 1) busy = 1'b1;
    else if (busy_mode == 2) busy = 1'b0;
    else if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin busy = 1'b1; rsp_left = rsp_len; end
    end else if (busy) begin
      if (rsp_left <= 1) busy = 1'b0; else rsp_left--;
    end else if (start === 1'b1) rsp_wait = rsp_dly;
    rst = r; wr_en = we; wr_data = wd; clr_err = ce;
    pre = model_q.size();
    @(negedge clk);
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      popped = start && !prev_start;
      if (popped) begin
        if (model_q.size() == 0) spur++;
        else begin
          exp_q.push_back(model_q.pop_front());
          got_q.push_back(tx_data);
        end
      end
      if (we && pre == DEPTH && !popped) model_ovf = 1'b1;
      else begin
        if (we) model_q.push_back(wd);
        if (ce) model_ovf = 1'b0;
      end
      if (level !== 5'(model_q.size())) lvl_mis++;
      if (tx_done) done_cnt++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (start && busy && prev_sb) sb_viol++;
    end
    prev_start = start;
    prev_sb    = start && busy;
  endtask

  task automatic do_reset();
    rsp_wait = 0; rsp_left = 0; busy = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    exp_q.delete(); got_q.delete();
    lvl_mis = 0; spur = 0; done_cnt = 0; max_lvl = 0; sb_viol = 0;
  endtask

  task automatic test_reset();
    busy_mode = 0;
    do_reset();
    vecs++; if (level !== 5'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
    vecs++; if ({full, start, tx_done, overflow, ack_err} !== 5'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 00000", {full, start, tx_done, overflow, ack_err}); end
    vecs++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
  endtask

  task automatic test_single();
    int rise, fall, dn, ndone;
    logic st_before, st_rise, pst;
    busy_mode = 0; rsp_dly = 1; rsp_len = 50;
    do_reset();
    cyc(1'b0, 1'b1, 8'hD3, 1'b0);
    vecs++; if ({level, start} !== {5'd1, 1'b0}) begin
      errs++; $display("FAIL single_after_write: got level=%0d start=%b want level=1 start=0", level, start); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vecs++; if ({start, tx_data, level} !== {1'b1, 8'hD3, 5'd0}) begin
      errs++; $display("FAIL single_armed: got start=%b tx=%h level=%0d want 1 d3 0", start, tx_data, level); end
    rise = -1; fall = -1; dn = -1; ndone = 0; st_before = 1'b0; st_rise = 1'b1; pst = start;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      if (busy && rise < 0) begin rise = i; st_rise = start; st_before = pst; end
      if (rise >= 0 && !busy && fall < 0) fall = i;
      if (tx_done) begin ndone++; if (dn < 0) dn = i; end
      pst = start;
    end
    vecs++; if ({st_before, st_rise} !== 2'b10) begin
      errs++; $display("FAIL single_start_drop: got before/at busy=%b%b want 10", st_before, st_rise); end
    vecs++; if (ndone !== 1 || dn !== fall) begin
      errs++; $display("FAIL single_tx_done: got %0d pulses at %0d want 1 at %0d", ndone, dn, fall); end
    vecs++; if (level !== 5'd0 || tx_data !== 8'hD3) begin
      errs++; $display("FAIL single_end: got level=%0d tx=%h want 0 d3", level, tx_data); end
  endtask

  task automatic test_burst();
    busy_mode = 0; rsp_dly = $urandom_range(1, 3); rsp_len = $urandom_range(3, 8);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 400 && done_cnt < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vecs++; if (done_cnt !== 4) begin errs++; $display("FAIL burst_done: got %0d want 4", done_cnt); end
    vecs++; if (max_lvl < 3 || max_lvl > 4) begin errs++; $display("FAIL burst_peak: got %0d want 3..4", max_lvl); end
    vecs++; if (got_q.size() !== 4) begin errs++; $display("FAIL burst_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      vecs++; if (got_q[i] !== 8'(i + 1)) begin errs++; $display("FAIL burst_order[%0d]: got %h want %h", i, got_q[i], 8'(i + 1)); end
    end
    vecs++; if (sb_viol !== 0 || lvl_mis !== 0) begin
      errs++; $display("FAIL burst_handshake: got start_busy=%0d level_errs=%0d want 0 0", sb_viol, lvl_mis); end
  endtask

  task automatic test_overflow();
    busy_mode = 1; rsp_dly = 2; rsp_len = 4;
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    vecs++; if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      errs++; $display("FAIL ovf_fill: got full=%b level=%0d ovf=%b want 1 16 0", full, level, overflow); end
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    vecs++; if ({full, level, overflow} !== {1'b1, 5'd16, 1'b1}) begin
      errs++; $display("FAIL ovf_drop: got full=%b level=%0d ovf=%b want 1 16 1", full, level, overflow); end
    busy_mode = 0; rsp_left = 0;
    for (int k = 0; k < 6 && got_q.size() == 0; k++) cyc(1'b0, 1'b1, 8'h55, 1'b0);
    vecs++; if ({got_q.size() == 1, full, level} !== {1'b1, 1'b1, 5'd16}) begin
      errs++; $display("FAIL ovf_push_pop: got pops=%0d full=%b level=%0d want 1 1 16", got_q.size(), full, level); end
    cyc(1'b0, 1'b1, 8'h77, 1'b1);
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    for (int i = 0; i < 1000 && done_cnt < DEPTH + 1; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vecs++; if (done_cnt !== DEPTH + 1 || got_q.size() !== DEPTH + 1) begin
      errs++; $display("FAIL ovf_drain: got done=%0d sent=%0d want 17 17", done_cnt, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL ovf_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (got_q.size() > 0 && got_q[got_q.size() - 1] !== 8'h55) begin
      errs++; $display("FAIL ovf_last: got %h want 55", got_q[got_q.size() - 1]); end
  endtask

  task automatic test_timeout();
    logic [7:0] b0, b1;
    int n, m;
    busy_mode = 2;
    do_reset();
    b0 = 8'($urandom); b1 = 8'($urandom);
    cyc(1'b0, 1'b1, b0, 1'b0);
    cyc(1'b0, 1'b1, b1, 1'b0);
    vecs++; if ({start, tx_data} !== {1'b1, b0}) begin
      errs++; $display("FAIL to_arm0: got start=%b tx=%h want 1 %h", start, tx_data, b0); end
    n = 1;
    for (int i = 0; i < 50; i++) begin cyc(1'b0, 1'b0, 8'h00, 1'b0); if (!start) break; n++; end
    vecs++; if (n !== ACK_TIMEOUT || ack_err !== 1'b1) begin
      errs++; $display("FAIL to_first: got start_cycles=%0d ack_err=%b want %0d 1", n, ack_err, ACK_TIMEOUT); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    vecs++; if ({ack_err, start, tx_data} !== {1'b0, 1'b1, b1}) begin
      errs++; $display("FAIL to_clr_rearm: got err=%b start=%b tx=%h want 0 1 %h", ack_err, start, tx_data, b1); end
    m = 1;
    for (int i = 0; i < 50; i++) begin cyc(1'b0, 1'b0, 8'h00, 1'b1); if (!start) break; m++; end
    vecs++; if (m !== ACK_TIMEOUT || ack_err !== 1'b1) begin
      errs++; $display("FAIL to_set_wins: got start_cycles=%0d ack_err=%b want %0d 1", m, ack_err, ACK_TIMEOUT); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    vecs++; if ({ack_err, level, done_cnt == 0} !== {1'b0, 5'd0, 1'b1}) begin
      errs++; $display("FAIL to_end: got err=%b level=%0d done=%0d want 0 0 0", ack_err, level, done_cnt); end
  endtask

  task automatic test_reset_mid();
    busy_mode = 0; rsp_dly = 1; rsp_len = 20;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin if (busy && !start) break; cyc(1'b0, 1'b0, 8'h00, 1'b0); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vecs++; if (level !== 5'd3) begin errs++; $display("FAIL mid_queued: got %0d want 3", level); end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    vecs++; if ({level, start, tx_data} !== {5'd0, 1'b0, 8'h00}) begin
      errs++; $display("FAIL mid_reset: got level=%0d start=%b tx=%h want 0 0 00", level, start, tx_data); end
    vecs++; if ({full, overflow, ack_err, tx_done} !== 4'b0) begin
      errs++; $display("FAIL mid_flags: got %b want 0000", {full, overflow, ack_err, tx_done}); end
    done_cnt = 0; got_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vecs++; if (done_cnt !== 0 || got_q.size() !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL mid_after: got done=%0d pops=%0d busy=%b want 0 0 0", done_cnt, got_q.size(), busy); end
  endtask

  task automatic test_random();
    busy_mode = 0; rsp_dly = 2; rsp_len = 3;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 20 == 0) begin rsp_dly = $urandom_range(1, 4); rsp_len = $urandom_range(1, 6); end
      cyc(1'b0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 30) == 0);
    end
    for (int i = 0; i < 3000 && (level != 0 || start || busy); i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vecs++; if (lvl_mis !== 0 || spur !== 0 || sb_viol !== 0) begin
      errs++; $display("FAIL rand_track: got level_errs=%0d spurious=%0d start_busy=%0d want 0 0 0", lvl_mis, spur, sb_viol); end
    vecs++; if (got_q.size() !== exp_q.size() || done_cnt !== got_q.size()) begin
      errs++; $display("FAIL rand_count: got sent=%0d done=%0d want %0d", got_q.size(), done_cnt, exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if ({overflow, ack_err} !== {model_ovf, 1'b0}) begin
      errs++; $display("FAIL rand_flags: got ovf=%b err=%b want %b 0", overflow, ack_err, model_ovf); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_err = 1'b0; busy = 1'b0;
    busy_mode = 0; rsp_dly = 1; rsp_len = 1; rsp_wait = 0; rsp_left = 0;
    model_ovf = 1'b0; prev_start = 1'b0; prev_sb = 1'b0;
    lvl_mis = 0; spur = 0; done_cnt = 0; max_lvl = 0; sb_viol = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
